countdown_timer_hms: RTL and testbench

COUNTDOWN_TIMER_HMS -- requirements
Module: countdown_timer_hms

---
 rtl/countdown_timer_hms.sv | 210 +++++++++++++++++++++
 tb/tb_countdown_timer_hms.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_hms.sv
`default_nettype none
// =============================================================================
// Module   : countdown_timer_hms
// Purpose  : H:M:S countdown timer with preset load, pause/resume and +/-1 s
//            trim. Optional macro AUTO_RELOAD_EN selects periodic mode.
// Revision : 1.0
// =============================================================================
module countdown_timer_hms #(
  parameter int TICK_DIV = 50_000_000,
  parameter int HOUR_MAX = 23,
  localparam int HW = $clog2(HOUR_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [HW-1:0] load_h,
  input  logic [5:0]    load_m,
  input  logic [5:0]    load_s,
  input  logic          start,
  input  logic          pause,
  input  logic          inc,
  input  logic          dec,
  output logic [HW-1:0] hours,
  output logic [5:0]    mins,
  output logic [5:0]    secs,
  output logic [1:0]    state,
  output logic          expired,
  output logic          done
);

  localparam int              DW         = $clog2(TICK_DIV);
  localparam logic [DW-1:0]   C_DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [HW-1:0]   C_HOUR_MAX = HW'(HOUR_MAX);
  localparam logic [5:0]      C_59       = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  state_e          state_q;
  logic [HW-1:0]   hours_q;
  logic [5:0]      mins_q;
  logic [5:0]      secs_q;
  logic [DW-1:0]   div_q;
  logic            expired_q;
  logic            done_q;

  logic            is_zero;
  logic            is_max;
  logic            is_last;
  logic            tick;
  logic            adjustable;
  logic [HW-1:0]   ld_h;
  logic [5:0]      ld_m;
  logic [5:0]      ld_s;
  logic [HW-1:0]   dec_h;
  logic [5:0]      dec_m;
  logic [5:0]      dec_s;
  logic [HW-1:0]   inc_h;
  logic [5:0]      inc_m;
  logic [5:0]      inc_s;

  assign is_zero    = (hours_q == '0) && (mins_q == '0) && (secs_q == '0);
  assign is_max     = (hours_q == C_HOUR_MAX) && (mins_q == C_59) && (secs_q == C_59);
  // Countdown always runs from a nonzero value, so 00:00:01 is the last step.
  assign is_last    = (hours_q == '0) && (mins_q == '0) && (secs_q == 6'd1);
  assign tick       = (state_q == ST_RUN) && (div_q == C_DIV_LAST);
  assign adjustable = (state_q == ST_IDLE) || (state_q == ST_PAUSE);

  assign ld_h = (load_h > C_HOUR_MAX) ? C_HOUR_MAX : load_h;
  assign ld_m = (load_m > C_59) ? C_59 : load_m;
  assign ld_s = (load_s > C_59) ? C_59 : load_s;

  always_comb begin
    dec_h = hours_q;
    dec_m = mins_q;
    dec_s = secs_q - 6'd1;
    if (secs_q == '0) begin
      dec_s = C_59;
      dec_m = mins_q - 6'd1;
      if (mins_q == '0) begin
        dec_m = C_59;
        dec_h = hours_q - HW'(1);
      end
    end
  end

  always_comb begin
    inc_h = hours_q;
    inc_m = mins_q;
    inc_s = secs_q + 6'd1;
    if (secs_q == C_59) begin
      inc_s = '0;
      inc_m = mins_q + 6'd1;
      if (mins_q == C_59) begin
        inc_m = '0;
        inc_h = hours_q + HW'(1);
      end
    end
  end

`ifdef AUTO_RELOAD_EN
  logic [HW-1:0] rl_h_q;
  logic [5:0]    rl_m_q;
  logic [5:0]    rl_s_q;
  logic          rl_nonzero;

  assign rl_nonzero = (rl_h_q != '0) || (rl_m_q != '0) || (rl_s_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rl_h_q <= '0;
      rl_m_q <= '0;
      rl_s_q <= '0;
    end else if (load && (state_q != ST_RUN)) begin
      rl_h_q <= ld_h;
      rl_m_q <= ld_m;
      rl_s_q <= ld_s;
    end
  end
`endif

  // A command that is ignored in the current state falls through to the
  // next lower-priority command (e.g. load in RUN still lets pause act).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hours_q   <= '0;
      mins_q    <= '0;
      secs_q    <= '0;
      div_q     <= '0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load && (state_q != ST_RUN)) begin
        hours_q   <= ld_h;
        mins_q    <= ld_m;
        secs_q    <= ld_s;
        state_q   <= ST_IDLE;
        div_q     <= '0;
        expired_q <= 1'b0;
      end else if (state_q == ST_RUN) begin
        if (tick) begin
          div_q <= '0;
          if (is_last) begin
            done_q <= 1'b1;
`ifdef AUTO_RELOAD_EN
            if (rl_nonzero) begin
              hours_q <= rl_h_q;
              mins_q  <= rl_m_q;
              secs_q  <= rl_s_q;
              if (pause) begin
                state_q <= ST_PAUSE;
              end
            end else begin
              secs_q    <= '0;
              state_q   <= ST_EXPIRED;
              expired_q <= 1'b1;
            end
`else
            secs_q    <= '0;
            state_q   <= ST_EXPIRED;
            expired_q <= 1'b1;
`endif
          end else begin
            hours_q <= dec_h;
            mins_q  <= dec_m;
            secs_q  <= dec_s;
            if (pause) begin
              state_q <= ST_PAUSE;
            end
          end
        end else if (pause) begin
          state_q <= ST_PAUSE;
          div_q   <= '0;
        end else begin
          div_q <= div_q + DW'(1);
        end
      end else if (start && adjustable && !is_zero) begin
        state_q <= ST_RUN;
        div_q   <= '0;
      end else if (adjustable && inc && !dec) begin
        if (!is_max) begin
          hours_q <= inc_h;
          mins_q  <= inc_m;
          secs_q  <= inc_s;
        end
      end else if (adjustable && dec && !inc) begin
        if (!is_zero) begin
          hours_q <= dec_h;
          mins_q  <= dec_m;
          secs_q  <= dec_s;
        end
      end
    end
  end

  assign hours   = hours_q;
  assign mins    = mins_q;
  assign secs    = secs_q;
  assign state   = state_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_hms.sv
`default_nettype none
// =============================================================================
// Module   : tb_countdown_timer_hms
// Purpose  : Directed and randomized bench for countdown_timer_hms against a
//            total-seconds reference model.
// Revision : 1.0
// =============================================================================
module tb_countdown_timer_hms;

  localparam int TICK_DIV = 4;
  localparam int HOUR_MAX = 23;
  localparam int HW       = $clog2(HOUR_MAX + 1);
  localparam int MAX_TOT  = HOUR_MAX * 3600 + 59 * 60 + 59;

  logic          clk = 1'b0;
  logic          reset, load, start, pause, inc, dec;
  logic [HW-1:0] load_h;
  logic [5:0]    load_m, load_s;
  logic [HW-1:0] hours;
  logic [5:0]    mins, secs;
  logic [1:0]    state;
  logic          expired, done;

  countdown_timer_hms #(.TICK_DIV(TICK_DIV), .HOUR_MAX(HOUR_MAX)) dut (
    .clk(clk), .reset(reset), .load(load), .load_h(load_h), .load_m(load_m),
    .load_s(load_s), .start(start), .pause(pause), .inc(inc), .dec(dec),
    .hours(hours), .mins(mins), .secs(secs), .state(state),
    .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: value held as total seconds; state 0..3 as the interface codes.
  int m_tot, m_state, m_phase, m_rl;
  bit m_done, m_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_step();
    int h, m, s;
    if (reset) begin
      m_tot = 0; m_state = 0; m_phase = 0; m_rl = 0; m_done = 0; m_exp = 0;
    end else begin
      m_done = 0;
      if (load && m_state != 1) begin
        h = (int'(load_h) > HOUR_MAX) ? HOUR_MAX : int'(load_h);
        m = (int'(load_m) > 59) ? 59 : int'(load_m);
        s = (int'(load_s) > 59) ? 59 : int'(load_s);
        m_tot = h * 3600 + m * 60 + s;
        m_state = 0; m_phase = 0; m_exp = 0;
`ifdef AUTO_RELOAD_EN
        m_rl = m_tot;
`endif
      end else if (m_state == 1) begin
        m_phase++;
        if (m_phase == TICK_DIV) begin
          m_phase = 0;
          m_tot--;
          if (m_tot == 0) begin
            m_done = 1;
            if (m_rl != 0) m_tot = m_rl;
            else begin m_state = 3; m_exp = 1; end
          end
          if (m_state == 1 && pause) m_state = 2;
        end else if (pause) begin
          m_state = 2; m_phase = 0;
        end
      end else if (start && m_state != 3 && m_tot != 0) begin
        m_state = 1; m_phase = 0;
      end else if (m_state != 3 && inc && !dec) begin
        if (m_tot < MAX_TOT) m_tot++;
      end else if (m_state != 3 && dec && !inc) begin
        if (m_tot > 0) m_tot--;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("hours",   hours,   m_tot / 3600);
    chk("mins",    mins,    (m_tot / 60) % 60);
    chk("secs",    secs,    m_tot % 60);
    chk("state",   state,   m_state);
    chk("expired", expired, m_exp);
    chk("done",    done,    m_done);
  endtask

  task automatic clear_inputs();
    reset = 0; load = 0; start = 0; pause = 0; inc = 0; dec = 0;
    load_h = '0; load_m = '0; load_s = '0;
  endtask

  task automatic drive(input bit rs, input bit ld, input int h, input int m, input int s,
                       input bit st, input bit pa, input bit in, input bit de);
    reset = rs; load = ld; load_h = HW'(h); load_m = 6'(m); load_s = 6'(s);
    start = st; pause = pa; inc = in; dec = de;
    step();
    clear_inputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    clear_inputs();

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_secs", secs, 0);
    chk("rst_state", state, 0);
    chk("rst_done", done, 0);

`ifndef AUTO_RELOAD_EN
    // Basic countdown to expiry.
    drive(0, 1, 0, 0, 3, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(4);  chk("cd_s2", secs, 2);
    idle(4);  chk("cd_s1", secs, 1);
    idle(4);  chk("cd_s0", secs, 0);
    chk("cd_done", done, 1);
    chk("cd_state", state, 3);
    idle(3);  chk("cd_done_low", done, 0);
    chk("cd_expired", expired, 1);
`endif

    // Borrow across minutes, saturation, zero start.
    drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(4);  chk("brw_m", mins, 0); chk("brw_s", secs, 59);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 1, 23, 59, 59, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("sat_h", hours, 23); chk("sat_s", secs, 59);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("dec0_s", secs, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("start0_state", state, 0);

    // Clamping and carry/borrow trims.
    drive(0, 1, 31, 63, 63, 0, 0, 0, 0);
    chk("clamp_h", hours, 23); chk("clamp_m", mins, 59);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("trim_dec_h", hours, 0); chk("trim_dec_m", mins, 59);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("trim_inc_h", hours, 1); chk("trim_inc_s", secs, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("trim_both_h", hours, 1);

    // Pause freezes value; resume ticks exactly TICK_DIV cycles later.
    drive(0, 1, 0, 0, 10, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(8);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(20); chk("frz_s", secs, 8); chk("frz_state", state, 2);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);  chk("res_hold", secs, 8);
    idle(1);  chk("res_tick", secs, 7);

    // Reset mid-run, load ignored in RUN, start+pause in RUN.
    idle(5);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mrst_s", secs, 0); chk("mrst_state", state, 0);
    drive(0, 1, 0, 0, 10, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 5, 0, 0, 0, 0);
    chk("ldrun_s", secs, 10);
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("stpa_state", state, 2);

`ifdef AUTO_RELOAD_EN
    // Periodic mode: done every 2*TICK_DIV cycles, stays in RUN.
    drive(0, 1, 0, 0, 2, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      idle(8);
      chk("rl_done", done, 1);
      chk("rl_secs", secs, 2);
      chk("rl_state", state, 1);
    end
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(499) == 0);
      load  = ($urandom_range(15) == 0);
      if ($urandom_range(1) == 0) begin
        load_h = '0; load_m = 6'($urandom_range(1)); load_s = 6'($urandom_range(5));
      end else begin
        load_h = HW'($urandom); load_m = 6'($urandom); load_s = 6'($urandom);
      end
      start = ($urandom_range(5) == 0);
      pause = ($urandom_range(19) == 0);
      inc   = ($urandom_range(9) == 0);
      dec   = ($urandom_range(9) == 0);
      step();
    end
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
